// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer queue: config bit positions,
// frame-engine states and frame width.
package spi_pkg;

    localparam int CFG_MODE   = 7;
    localparam int CFG_LEN    = 6;
    localparam int CFG_CPOL   = 5;
    localparam int CFG_CPHA   = 4;
    localparam int CFG_DIV_HI = 3;
    localparam int CFG_DIV_LO = 1;

    localparam int FRAME_W = 16;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        PUSH
    } state_t;

    // Bytes per frame selected by the length bit of the config byte.
    function automatic logic [1:0] frame_bytes(input logic [7:0] c);
        return c[CFG_LEN] ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with occupancy output; pushes when full are dropped
// and pops when empty are ignored. Head entry is visible without a pop.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (level_reg != LW'(DEPTH));
    assign do_pop  = pop && (level_reg != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign level = level_reg;

endmodule

// File: rtl/spi_xfer_queue.sv
// CPU-side TX/RX byte queue feeding an SPI core with 8/16-bit frames.
// Optional sticky error flags are enabled with SPI_XFER_QUEUE_ERR_EN.
module spi_xfer_queue
    import spi_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef SPI_XFER_QUEUE_ERR_EN
    input  logic                   err_clr,
    output logic [2:0]             err,
`endif
    input  logic                   wr_en,
    input  logic                   wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   busy,
    output logic [7:0]             cfg,
    output logic                   cfg_valid,
    output logic [FRAME_W-1:0]     tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [FRAME_W-1:0]     rx_data,
    input  logic                   rx_valid
);
    localparam int LW = $clog2(DEPTH) + 1;

    state_t              state_reg, state_next;
    logic [1:0]          cnt_reg;
    logic [7:0]          cfg_reg;
    logic                cfg_valid_reg;
    logic [FRAME_W-1:0]  tx_data_reg;
    logic [FRAME_W-1:0]  rx_buf_reg;
    logic [DATA_W-1:0]   rd_data_reg;
    logic                rd_valid_reg;

    logic [1:0]          bytes;
    logic                cfg_wr, tx_wr, cfg_accept, start;
    logic                tx_pop, rx_push, rx_pop, rx_empty;
    logic [7:0]          tx_head, rx_head, rx_push_data;
    logic [LW-1:0]       rx_space;
    logic [7:0]          rx_lane [2];

    assign bytes      = frame_bytes(cfg_reg);
    assign cfg_wr     = wr_en && !wr_addr;
    assign tx_wr      = wr_en && wr_addr;
    assign cfg_accept = cfg_wr && (state_reg == IDLE);
    assign rx_empty   = (rx_level == '0);
    assign rx_pop     = rd_en && !rx_empty;
    assign rx_space   = LW'(DEPTH) - rx_level;

    // A same-cycle config write holds off the start so the frame length
    // cannot change under a frame that is just launching.
    assign start = cfg_valid_reg && !cfg_wr &&
                   (tx_level >= LW'(bytes)) && (rx_space >= LW'(bytes));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign rx_lane[gi] = rx_buf_reg[gi*8 +: 8];
        end
    endgenerate

    sync_fifo #(.DEPTH(DEPTH), .W(8)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_wr), .push_data(wr_data),
        .pop(tx_pop), .head(tx_head), .level(tx_level)
    );

    sync_fifo #(.DEPTH(DEPTH), .W(8)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_push_data),
        .pop(rx_pop), .head(rx_head), .level(rx_level)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start)                state_next = ISSUE;
            ISSUE: if (tx_valid && tx_ready) state_next = WAIT;
            WAIT:  if (rx_valid)             state_next = PUSH;
            PUSH:  if (cnt_reg == bytes - 2'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_pop       = (state_reg == ISSUE) && (cnt_reg != bytes);
        tx_valid     = (state_reg == ISSUE) && (cnt_reg == bytes);
        rx_push      = (state_reg == PUSH);
        busy         = (state_reg != IDLE);
        rx_push_data = (bytes == 2'd2 && cnt_reg == 2'd0) ? rx_lane[1] : rx_lane[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            cfg_reg       <= '0;
            cfg_valid_reg <= 1'b0;
            tx_data_reg   <= '0;
            rx_buf_reg    <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
        end else begin
            if (state_next != state_reg)  cnt_reg <= '0;
            else if (tx_pop || rx_push)   cnt_reg <= cnt_reg + 2'd1;
            if (cfg_accept) begin
                cfg_reg       <= {wr_data[7:1], 1'b0};
                cfg_valid_reg <= 1'b1;
            end
            // First popped byte lands in the low lane and shifts up on the second.
            if (tx_pop) begin
                tx_data_reg <= (cnt_reg == 2'd0) ? {8'h00, tx_head}
                                                 : {tx_data_reg[7:0], tx_head};
            end
            if (state_reg == WAIT && rx_valid) rx_buf_reg <= rx_data;
            rd_valid_reg <= rx_pop;
            if (rx_pop) rd_data_reg <= rx_head;
        end
    end

`ifdef SPI_XFER_QUEUE_ERR_EN
    logic [2:0] err_reg;
    logic [2:0] err_new;
    logic       tx_full;

    assign tx_full = (tx_level == LW'(DEPTH));
    assign err_new = {cfg_wr && (state_reg != IDLE), rd_en && rx_empty, tx_wr && tx_full};

    always_ff @(posedge clk) begin
        if (rst) err_reg <= '0;
        else     err_reg <= (err_clr ? 3'b000 : err_reg) | err_new;
    end

    assign err = err_reg;
`endif

    assign cfg       = cfg_reg;
    assign cfg_valid = cfg_valid_reg;
    assign tx_data   = tx_data_reg;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;

endmodule
